xform_stream: RTL and testbench

XFORM_STREAM -- requirements
Module: xform_stream

---
 rtl/xform_stream_pkg.sv | 19 +
 rtl/xform_stream_if.sv | 29 ++
 rtl/xform_dot4.sv | 21 ++
 rtl/xform_stream.sv | 140 ++++++++++++++
 tb/tb_xform_stream.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xform_stream_pkg.sv
// Shared types and constants for the 4x4 matrix-vector stream transform.
package xform_stream_pkg;

    localparam int MAT_DIM    = 4;
    localparam int COEF_CNT   = MAT_DIM * MAT_DIM;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_OUT_W  = 32;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } xform_state_t;

    // Row-major index lies on the main diagonal of the coefficient matrix.
    function automatic logic is_diag(input int idx);
        return (idx / MAT_DIM) == (idx % MAT_DIM);
    endfunction

endpackage

// File: rtl/xform_stream_if.sv
// Input word stream and result stream of the transform, with status flag.
interface xform_stream_if
    import xform_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic              in_sel;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              coef_loaded;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, coef_loaded
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, coef_loaded
    );

endinterface

// File: rtl/xform_dot4.sv
// Combinational 4-term unsigned dot product, wrapped modulo 2^OUT_W.
module xform_dot4
    import xform_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic [DATA_W-1:0] coef [MAT_DIM],
    input  logic [DATA_W-1:0] pix  [MAT_DIM],
    output logic [OUT_W-1:0]  result
);

    // Working in OUT_W bits throughout gives the same residue as full products.
    always_comb begin
        result = '0;
        for (int k = 0; k < MAT_DIM; k++) begin
            result = result + OUT_W'(coef[k]) * OUT_W'(pix[k]);
        end
    end

endmodule

// File: rtl/xform_stream.sv
// Streams coefficient and pixel words in, emits four row dot products per pixel vector.
module xform_stream
    import xform_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input logic           clk,
    input logic           reset,
    xform_stream_if.slave bus
);

    xform_state_t      state;
    xform_state_t      state_next;
    logic [DATA_W-1:0] coef_q   [COEF_CNT];
    logic [DATA_W-1:0] pix_q    [MAT_DIM];
    logic [DATA_W-1:0] pix_next [MAT_DIM];
    logic [DATA_W-1:0] row_coef [MAT_DIM];
    logic [3:0]        coef_idx;
    logic [1:0]        pix_cnt;
    logic [1:0]        row_q;
    logic [1:0]        calc_row;
    logic [OUT_W-1:0]  dot_result;
    logic [OUT_W-1:0]  out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              coef_loaded_q;
    logic              in_ready_c;
    logic              start_emit;
    logic              finish_emit;
    logic              word_accept;
    logic              coef_accept;
    logic              pix_accept;
    logic              result_fire;

    assign word_accept = bus.in_valid && in_ready_c;
    assign coef_accept = word_accept && bus.in_sel;
    assign pix_accept  = word_accept && !bus.in_sel;
    assign result_fire = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        start_emit  = 1'b0;
        finish_emit = 1'b0;
        case (state)
            LOAD: begin
                in_ready_c = 1'b1;
                if (pix_accept && pix_cnt == 2'd3) begin
                    start_emit = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (result_fire && row_q == 2'd3) begin
                    finish_emit = 1'b1;
                    state_next  = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // The dot product is fed the row about to be registered: row 0 (with the
    // incoming 4th pixel bypassed in) on entry, row_q+1 on each handshake.
    always_comb begin
        calc_row = (state == EMIT) ? row_q + 2'd1 : 2'd0;
        for (int k = 0; k < MAT_DIM; k++) begin
            pix_next[k] = (pix_accept && pix_cnt == 2'(k)) ? bus.in_data : pix_q[k];
            row_coef[k] = coef_q[{calc_row, 2'(k)}];
        end
    end

    xform_dot4 #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_dot4 (
        .coef   (row_coef),
        .pix    (pix_next),
        .result (dot_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COEF_CNT; i++) begin
                coef_q[i] <= is_diag(i) ? DATA_W'(1) : '0;
            end
            for (int k = 0; k < MAT_DIM; k++) begin
                pix_q[k] <= '0;
            end
            coef_idx      <= 4'd0;
            coef_loaded_q <= 1'b0;
            pix_cnt       <= 2'd0;
            row_q         <= 2'd0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
        end else begin
            if (coef_accept) begin
                coef_q[coef_idx] <= bus.in_data;
                coef_idx         <= coef_idx + 4'd1;
                if (coef_idx == 4'd15) begin
                    coef_loaded_q <= 1'b1;
                end
            end
            if (pix_accept) begin
                pix_q[pix_cnt] <= bus.in_data;
                pix_cnt        <= pix_cnt + 2'd1;
            end
            if (start_emit) begin
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
                out_data_q  <= dot_result;
                row_q       <= 2'd0;
            end else if (finish_emit) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (result_fire) begin
                out_data_q <= dot_result;
                out_last_q <= (row_q == 2'd2);
                row_q      <= row_q + 2'd1;
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.coef_loaded = coef_loaded_q;

endmodule

// File: tb/tb_xform_stream.sv
// Directed bench for xform_stream: a matrix/vector reference model checked every cycle plus literal results.
module tb_xform_stream;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    xform_stream_if #(.DATA_W(16), .OUT_W(32)) bus ();

    xform_stream #(.DATA_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    int unsigned m_coef [16];
    int unsigned m_pix  [4];
    int          m_idx;
    int          m_pcnt;
    bit          m_loaded;
    bit          chk_en = 1'b0;
    logic [31:0] exp_q [$];
    logic [31:0] got   [$];
    int          stall_row  = -1;
    int          stall_left = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    // Matrix times vector in plain arithmetic, queued as the four expected beats.
    task automatic modelPush();
        for (int r = 0; r < 4; r++) begin
            bit [63:0] s = 64'd0;
            for (int k = 0; k < 4; k++) s += 64'(m_coef[r*4+k]) * 64'(m_pix[k]);
            exp_q.push_back(s[31:0]);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) m_coef[i] = (i / 4 == i % 4) ? 1 : 0;
        for (int k = 0; k < 4; k++) m_pix[k] = 0;
        m_idx    = 0;
        m_pcnt   = 0;
        m_loaded = 1'b0;
        exp_q.delete();
    endtask

    // Per-cycle compare, out_ready driver and model update, all on the falling edge.
    initial begin
        bit exp_valid;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                modelReset();
                chk_en        = 1'b1;
                bus.out_ready = 1'b1;
                continue;
            end
            exp_valid = (exp_q.size() > 0);
            if (chk_en) begin
                checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
                checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, !exp_valid});
                checkOutput("coef_loaded", {31'd0, bus.coef_loaded}, {31'd0, m_loaded});
                if (exp_valid) begin
                    checkOutput("out_data", bus.out_data, exp_q[0]);
                    checkOutput("out_last", {31'd0, bus.out_last}, {31'd0, exp_q.size() == 1});
                end
            end
            if (exp_valid && (4 - exp_q.size()) == stall_row && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (exp_valid) begin
                if (bus.out_ready) begin
                    got.push_back(bus.out_data);
                    void'(exp_q.pop_front());
                end
            end else if (bus.in_valid) begin
                if (bus.in_sel) begin
                    m_coef[m_idx] = 32'(bus.in_data);
                    if (m_idx == 15) m_loaded = 1'b1;
                    m_idx = (m_idx + 1) % 16;
                end else begin
                    m_pix[m_pcnt] = 32'(bus.in_data);
                    m_pcnt++;
                    if (m_pcnt == 4) begin
                        m_pcnt = 0;
                        modelPush();
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input bit sel, input int unsigned data);
        int cyc = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = 16'(data);
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.in_ready && cyc < 200);
        checkOutput("word_accept", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic sendPixels(input int unsigned p0, p1, p2, p3);
        applyStimulus(1'b0, p0);
        applyStimulus(1'b0, p1);
        applyStimulus(1'b0, p2);
        applyStimulus(1'b0, p3);
    endtask

    task automatic waitResults(input int n);
        int cyc = 0;
        while (got.size() < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("result_count", 32'(got.size()), 32'(n));
    endtask

    task automatic checkResults(input string tag, input logic [31:0] e0, e1, e2, e3);
        checkOutput({tag, "_row0"}, got[0], e0);
        checkOutput({tag, "_row1"}, got[1], e1);
        checkOutput({tag, "_row2"}, got[2], e2);
        checkOutput({tag, "_row3"}, got[3], e3);
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        checkOutput({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        checkOutput({tag, "_out_last"}, {31'd0, bus.out_last}, 32'd0);
        checkOutput({tag, "_out_data"}, bus.out_data, 32'd0);
        checkOutput({tag, "_coef_loaded"}, {31'd0, bus.coef_loaded}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int unsigned coefs [16] = '{1,1,2,3, 5,6,7,3, 1,2,3,2, 4,5,3,5};
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkResetState("reset");

        // Identity matrix after reset passes the vector straight through.
        got.delete();
        sendPixels(7, 8, 9, 10);
        waitResults(4);
        checkResults("identity", 32'd7, 32'd8, 32'd9, 32'd10);
        checkOutput("identity_coef_loaded", {31'd0, bus.coef_loaded}, 32'd0);

        got.delete();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, coefs[i]);
        sendPixels(2, 5, 3, 1);
        waitResults(4);
        checkResults("matrix", 32'd16, 32'd64, 32'd23, 32'd47);
        checkOutput("matrix_coef_loaded", {31'd0, bus.coef_loaded}, 32'd1);

        // Downstream stalls three cycles on row 1.
        got.delete();
        stall_row  = 1;
        stall_left = 3;
        sendPixels(2, 5, 3, 1);
        waitResults(4);
        checkResults("stall", 32'd16, 32'd64, 32'd23, 32'd47);
        checkOutput("stall_consumed", 32'(stall_left), 32'd0);
        stall_row = -1;

        // Rows 0 and 1 rewritten to unit rows between pixel words.
        got.delete();
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b0, 1);
        waitResults(4);
        checkResults("interleave", 32'd2, 32'd5, 32'd23, 32'd47);

        // Reset lands while row 2 is stalled; the rest of the vector is dropped.
        got.delete();
        stall_row  = 2;
        stall_left = 1000;
        sendPixels(2, 5, 3, 1);
        waitResults(2);
        repeat (3) @(negedge clk);
        resetPulse();
        stall_row  = -1;
        stall_left = 0;
        checkOutput("midreset_beats", 32'(got.size()), 32'd2);
        checkOutput("midreset_row0", got[0], 32'd2);
        checkOutput("midreset_row1", got[1], 32'd5);
        checkResetState("midreset");
        repeat (4) @(negedge clk);
        checkOutput("midreset_no_beats", 32'(got.size()), 32'd2);
        got.delete();
        sendPixels(1, 2, 3, 4);
        waitResults(4);
        checkResults("after_reset", 32'd1, 32'd2, 32'd3, 32'd4);

        // Full-scale operands wrap modulo 2^32.
        got.delete();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'hFFFF);
        sendPixels(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF);
        waitResults(4);
        checkResults("wrap", 32'hFFF80004, 32'hFFF80004, 32'hFFF80004, 32'hFFF80004);

        repeat (4) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
